// File: rtl/spi_reg_bank.sv
// Byte-level command decoder and register bank behind an SPI slave.
// Each transaction uses two frames: a command byte (rw + address), then a data byte.
module spi_reg_bank #(
    parameter int          NUM_REGS  = 16,
    parameter int          ADDR_W    = 4,
    parameter int          TIMEOUT   = 100000,
    parameter logic [7:0]  DEVICE_ID = 8'h5A
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    input  logic [6:0]              status_in,
    output logic [7:0]              tx_byte,
    output logic [NUM_REGS*8-1:0]   reg_out,
    output logic                    wr_strobe,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic                    err,
    output logic                    busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_CMD   = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ok;
    logic              rd_pend;
    logic [7:0]        rw_regs [NUM_REGS];

    logic       rx_addr_ok;
    logic       timeout_hit;
    logic       write_ok;
    logic       rd_load;
    logic       err_set;
    logic       err_clr;
    logic [7:0] rd_value;

    assign busy        = (state != S_CMD);
    assign rx_addr_ok  = ({1'b0, rx_byte[6:0]} < 8'(NUM_REGS));
    assign timeout_hit = busy && !rx_valid && (cnt == CNT_W'(TIMEOUT - 1));
    assign write_ok    = cmd_ok && (cmd_addr > ADDR_W'(1));
    // The read value is loaded one edge after the command, unless a timeout pre-empts it.
    assign rd_load     = (state == S_RDATA) && rd_pend && !rx_valid && !timeout_hit;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_value = 8'h00;
        if (cmd_ok) begin
            if (cmd_addr == '0)
                rd_value = DEVICE_ID;
            else if (cmd_addr == ADDR_W'(1))
                rd_value = {err, status_in};
            else
                rd_value = rw_regs[cmd_addr];
        end
    end

    always_comb begin
        err_set = 1'b0;
        err_clr = 1'b0;
        if (state == S_CMD && rx_valid && !rx_addr_ok)
            err_set = 1'b1;
        if (state == S_WDATA && rx_valid && !write_ok)
            err_set = 1'b1;
        if (timeout_hit)
            err_set = 1'b1;
        if (rd_load && cmd_ok && cmd_addr == ADDR_W'(1))
            err_clr = 1'b1;
    end

    always_comb begin
        reg_out       = '0;
        reg_out[7:0]  = DEVICE_ID;
        reg_out[15:8] = {err, status_in};
        for (int n = 2; n < NUM_REGS; n++)
            reg_out[n*8 +: 8] = rw_regs[n];
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= S_CMD;
            cnt       <= '0;
            cmd_addr  <= '0;
            cmd_ok    <= 1'b0;
            rd_pend   <= 1'b0;
            tx_byte   <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err       <= 1'b0;
            // NOTE: the register array is reset explicitly because the outside world sees it through reg_out; this keeps it in flops, not RAM.
            for (int n = 0; n < NUM_REGS; n++)
                rw_regs[n] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            case (state)
                S_CMD: begin
                    if (rx_valid) begin
                        cmd_addr <= rx_byte[ADDR_W-1:0];
                        cmd_ok   <= rx_addr_ok;
                        cnt      <= '0;
                        if (rx_byte[7]) begin
                            state   <= S_RDATA;
                            rd_pend <= 1'b1;
                        end else begin
                            state <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (rx_valid) begin
                        if (write_ok) begin
                            rw_regs[cmd_addr] <= rx_byte;
                            wr_strobe         <= 1'b1;
                            wr_addr           <= cmd_addr;
                        end
                        state <= S_CMD;
                    end else if (timeout_hit) begin
                        state   <= S_CMD;
                        tx_byte <= 8'h00;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RDATA: begin
                    rd_pend <= 1'b0;
                    if (rx_valid) begin
                        tx_byte <= 8'h00;
                        state   <= S_CMD;
                    end else if (timeout_hit) begin
                        state   <= S_CMD;
                        tx_byte <= 8'h00;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (rd_load)
                            tx_byte <= rd_value;
                    end
                end

                default: begin
                    state <= S_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized and directed bench for spi_reg_bank using a transaction-level model and scoreboard queues.
module tb_spi_reg_bank;

    localparam int         NUM_REGS  = 16;
    localparam int         ADDR_W    = 4;
    localparam int         TIMEOUT   = 50;
    localparam logic [7:0] DEVICE_ID = 8'h5A;

    logic                  clock = 1'b0;
    logic                  rst;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [6:0]            status_in;
    logic [7:0]            tx_byte;
    logic [NUM_REGS*8-1:0] reg_out;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  err;
    logic                  busy;

    spi_reg_bank #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .DEVICE_ID(DEVICE_ID)
    ) dut (
        .clock(clock), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .status_in(status_in), .tx_byte(tx_byte), .reg_out(reg_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { int due; logic [7:0] val; } tx_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_exp_t;

    tx_exp_t    exp_tx [$];
    wr_exp_t    exp_wr [$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_regs [NUM_REGS];
    logic       m_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations, decoupled from stimulus.
    always @(negedge clock) begin
        if (!rst) begin
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    check("wr_strobe_unexpected", {31'd0, wr_strobe}, 32'd0);
                end else begin
                    wr_exp_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
                    check("wr_reg_value", {24'd0, reg_out[e.addr*8 +: 8]}, {24'd0, e.data});
                end
            end
            while (exp_tx.size() > 0 && exp_tx[0].due <= cyc) begin
                tx_exp_t t;
                t = exp_tx.pop_front();
                check("tx_byte", {24'd0, tx_byte}, {24'd0, t.val});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after a posedge; returns just after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b, output int c);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        c = cyc;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_err = 1'b0;
    endtask

    // One complete command+data transaction, evaluated from the protocol rules.
    task automatic txn(input logic [7:0] cmd, input logic [7:0] data, input int gap);
        int         c;
        logic       ok;
        int         a;
        logic [7:0] v;
        a  = int'(cmd[6:0]);
        ok = (a < NUM_REGS);
        send_byte(cmd, c);
        if (!ok) m_err = 1'b1;
        if (cmd[7]) begin
            if (!ok)         v = 8'h00;
            else if (a == 0) v = DEVICE_ID;
            else if (a == 1) begin
                v = {m_err, status_in};
                m_err = 1'b0;
            end else         v = m_regs[a];
            exp_tx.push_back('{due: c + 1, val: v});
        end
        idle(gap);
        send_byte(data, c);
        if (cmd[7]) begin
            exp_tx.push_back('{due: c, val: 8'h00});
        end else if (ok && a >= 2) begin
            m_regs[a] = data;
            exp_wr.push_back('{addr: ADDR_W'(a), data: data});
        end else begin
            m_err = 1'b1;
        end
        idle(5);
    endtask

    task automatic check_regs(input string name);
        for (int i = 2; i < NUM_REGS; i++)
            check(name, {24'd0, reg_out[i*8 +: 8]}, {24'd0, m_regs[i]});
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        status_in = 7'h00;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        idle(10);

        check("reset_tx", {24'd0, tx_byte}, 32'h00);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_id_slot", {24'd0, reg_out[7:0]}, {24'd0, DEVICE_ID});
        check_regs("reset_rw_slot");

        // Write/readback of register 3.
        txn(8'h03, 8'hC3, 5);
        check("wr3_err", {31'd0, err}, {31'd0, m_err});
        txn(8'h83, 8'hFF, 5);
        txn(8'h80, 8'h00, 5);
        txn(8'h01, 8'h77, 5);
        check("wr_status_err", {31'd0, err}, {31'd0, m_err});
        status_in = 7'h15;
        txn(8'h81, 8'h00, 5);
        check("rd_status_clears_err", {31'd0, err}, {31'd0, m_err});

        // Out-of-range addresses.
        txn(8'h10, 8'hAA, 5);
        check("bad_wr_err", {31'd0, err}, {31'd0, m_err});
        txn(8'h90, 8'h00, 5);
        check("bad_rd_err", {31'd0, err}, {31'd0, m_err});
        check_regs("after_bad_addr");

        // Timeout: busy stays high exactly TIMEOUT cycles after the command edge.
        send_byte(8'h05, c);
        idle(TIMEOUT - 1);
        check("timeout_busy_before", {31'd0, busy}, 32'd1);
        idle(1);
        check("timeout_busy_after", {31'd0, busy}, 32'd0);
        m_err = 1'b1;
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_tx", {24'd0, tx_byte}, 32'h00);
        idle(10);
        txn(8'h05, 8'h11, 5);
        check("resync_reg5", {24'd0, reg_out[5*8 +: 8]}, 32'h11);

        // Data frame landing on the final timeout cycle still completes the write.
        txn(8'h07, 8'h3C, TIMEOUT - 1);
        check("boundary_reg7", {24'd0, reg_out[7*8 +: 8]}, 32'h3C);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic [6:0] a;
            logic       rw;
            a  = 7'($urandom_range(0, NUM_REGS + 3));
            rw = 1'($urandom_range(0, 1));
            status_in = 7'($urandom);
            txn({rw, a}, 8'($urandom), 5);
            check("rand_err", {31'd0, err}, {31'd0, m_err});
            check("rand_busy", {31'd0, busy}, 32'd0);
        end
        check_regs("rand_regs");

        // Reset in the middle of a transaction aborts it; next byte is a command.
        send_byte(8'h06, c);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_reset();
        idle(4);
        send_byte(8'h22, c);
        m_err = 1'b1;
        idle(3);
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_err", {31'd0, err}, 32'd1);
        check("midrst_reg6", {24'd0, reg_out[6*8 +: 8]}, 32'h00);
        check("midrst_tx", {24'd0, tx_byte}, 32'h00);
        send_byte(8'h44, c);
        idle(5);
        check("midrst_done_busy", {31'd0, busy}, 32'd0);
        check_regs("midrst_regs");

        idle(5);
        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Byte-level command decoder and register file that sits directly downstream of the SPI slave.
- Consumes each received byte (rx_byte plus one-cycle rx_valid pulse issued after SS rises) and presents the response byte (tx_byte) that the SPI slave loads at the next SS falling edge.
- Protocol is two SPI frames per transaction: a command frame, then a data frame.
- Exposes writable registers as a flat bus for the rest of the FPGA test logic.

Parameters:
- NUM_REGS, 16: number of registers (2..128); reg 0 = ID, reg 1 = status, regs 2..NUM_REGS-1 are RW.
- ADDR_W, 4: width of wr_addr; must equal clog2(NUM_REGS).
- TIMEOUT, 100000: clock cycles allowed between command frame and data frame before aborting.
- DEVICE_ID, 8'h5A: constant value returned by reg 0.

Ports:
- clock  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  8  received byte from SPI slave; valid when rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received frame.
- status_in  in  7  live status bits, readable via reg 1.
- tx_byte  out  8  response byte to SPI slave data input; registered.
- reg_out  out  NUM_REGS*8  flat register image, reg n at [8n+7:8n]; slots 0/1 read as DEVICE_ID/status.
- wr_strobe  out  1  one-cycle pulse when an RW register is written.
- wr_addr  out  ADDR_W  address of the last write; valid with wr_strobe, held afterwards.
- err  out  1  sticky protocol error flag.
- busy  out  1  1 while a transaction is waiting for its data frame (state != S_CMD).

Behaviour:
- Reset (rst=1 at a clock edge): state S_CMD; RW regs, tx_byte, wr_addr, err, wr_strobe, timeout counter all 0. Reset mid-transaction aborts it with no write.
- Command byte: bit7 = RW (1 = read, 0 = write); bits[6:0] = address. The address is valid iff bits[6:0] < NUM_REGS.
- S_CMD, on rx_valid: latch rw and addr, clear the timeout counter.
  - Write: go to S_WDATA.
  - Read: go to S_RDATA. On the next edge, tx_byte <= read value (DEVICE_ID; {err, status_in}; reg[addr]; or 8'h00 if the address is invalid). This gives 1-cycle latency from rx_valid.
- Reading reg 1 clears err in the same cycle tx_byte is loaded; the loaded byte shows the pre-clear err.
- S_WDATA, on rx_valid:
  - If addr is valid and >= 2: reg[addr] <= rx_byte, wr_strobe=1 for exactly one cycle, wr_addr <= addr.
  - Else: no write and err <= 1.
  - Either way, go to S_CMD.
- S_RDATA, on rx_valid: the byte shifted in is ignored; tx_byte <= 8'h00; go to S_CMD.
- Invalid address in a command: err <= 1 at command time; framing still consumes the data frame.
- Timeout: counter increments each cycle in S_WDATA/S_RDATA. On reaching TIMEOUT-1 without rx_valid: go to S_CMD, tx_byte <= 8'h00, err <= 1, no write. If rx_valid arrives on that same cycle, rx_valid wins and the transaction completes normally.
- Error set and clear in the same cycle: set wins.
- rx_valid is never asserted on consecutive cycles. Any pulse is accepted in any state; there is no back-pressure.
- System constraint: the SPI master keeps SS high for at least 4 clock cycles between frames, so tx_byte is stable before the SPI slave samples it.
- tx_byte changes only on the edges listed above. It is otherwise held, including 8'h00 while idle in S_CMD.

Test Plan:
- Reset, then idle 10 cycles -> tx_byte=00, err=0, busy=0, reg_out RW slots all 0.
- Frames 0x03, 0xC3 -> reg_out[31:24]=C3, wr_strobe high exactly 1 cycle, wr_addr=3, err=0; then frames 0x83, 0xFF -> tx_byte=C3 one cycle after the first rx_valid, 00 after the second.
- Read 0x80, dummy -> tx_byte=5A. Write 0x01, 0x77 -> reg 1 unchanged, err=1. Read 0x81 with status_in=7'h15 -> tx_byte=95, err=0 afterwards.
- Command 0x10 (NUM_REGS=16), then 0xAA -> no write, no wr_strobe, err=1. Command 0x90 -> tx_byte=00, err=1.
- Command 0x05, then TIMEOUT+10 cycles with no rx_valid -> busy falls after TIMEOUT cycles, err=1. Next frames 0x05, 0x11 -> reg 5 = 11 (framing resynced).
- Command 0x06, assert rst for 1 cycle, then frame 0x22 -> 0x22 treated as a command (write to addr 0x22 is invalid), reg 6 unchanged, busy=1.
